// File: rtl/fetch_pair_buffer.sv
// Circular instruction buffer presenting the two oldest entries as an in-order pair to a dual-issue scheduler.
// Optional sticky overrun_err output enabled by defining FETCH_BUF_OVERRUN_CHECK_EN.
module fetch_pair_buffer #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fill_valid,
  output logic                     fill_ready,
  input  logic [31:0]              fill_instr,
  input  logic [31:0]              fill_pc,
  input  logic                     flush,
  input  logic [1:0]               issue_count,
  output logic [31:0]              instruction0,
  output logic [31:0]              instruction1,
  output logic [31:0]              pc0,
  output logic                     nothing_filled,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_BUF_OVERRUN_CHECK_EN
  ,
  output logic                     overrun_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Each entry holds {pc, instr}.
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_p1;

  logic          push;
  logic          retire_legal;
  logic [1:0]    n_eff;

  assign fill_ready   = (count != CW'(DEPTH));
  assign push         = fill_valid && fill_ready;
  assign retire_legal = (issue_count != 2'd3) && (CW'(issue_count) <= count);
  assign n_eff        = retire_legal ? issue_count : 2'd0;
  assign rd_ptr_p1    = rd_ptr + AW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(n_eff);
      count  <= count + CW'(push) - CW'(n_eff);
    end
  end

  // NOTE: the storage array has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {fill_pc, fill_instr};
  end

`ifdef FETCH_BUF_OVERRUN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         overrun_err <= 1'b0;
    else if (!flush && !retire_legal) overrun_err <= 1'b1;
  end
`endif

  assign instruction0   = (count >= CW'(1)) ? mem[rd_ptr][31:0]    : NOP_WORD;
  assign instruction1   = (count >= CW'(2)) ? mem[rd_ptr_p1][31:0] : NOP_WORD;
  assign pc0            = (count >= CW'(1)) ? mem[rd_ptr][63:32]   : 32'd0;
  assign nothing_filled = (count < CW'(2));

endmodule
